full_adder_1b: RTL and testbench
================================

FULL_ADDER_1B -- requirements
Module: full_adder_1b

Interface
REQ-001 Parameter: none; all widths fixed at 1 bit.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; sampled only on rising clk edge.
REQ-004 a  input  1  first addend bit.
REQ-005 b  input  1  second addend bit.
REQ-006 cin  input  1  carry-in bit.
REQ-007 in_valid  input  1  qualifies a/b/cin for registered capture.
REQ-008 sum  output  1  combinational sum bit.
REQ-009 cout  output  1  combinational carry-out bit.
REQ-010 p  output  1  combinational propagate, a XOR b.
REQ-011 g  output  1  combinational generate, a AND b.
REQ-012 sum_q  output  1  registered sum.
REQ-013 cout_q  output  1  registered carry-out.
REQ-014 out_valid  output  1  high for the cycle in which sum_q/cout_q hold a newly captured result.

Function
REQ-015 sum SHALL equal a XOR b XOR cin at all times, zero clock latency, independent of clk, rst and in_valid.
REQ-016 cout SHALL equal (a AND b) OR (cin AND (a XOR b)) at all times, zero latency.
REQ-017 {cout,sum} SHALL equal the 2-bit arithmetic sum a + b + cin for all 8 input combinations; no overflow possible.
REQ-018 p and g SHALL be combinational; cout SHALL equal g OR (p AND cin).
REQ-019 On a rising edge with rst=0 and in_valid=1: sum_q <= sum, cout_q <= cout, out_valid <= 1; latency exactly one cycle.
REQ-020 On a rising edge with rst=0 and in_valid=0: sum_q/cout_q hold previous values, out_valid <= 0.
REQ-021 Back-to-back in_valid=1 cycles SHALL each produce a result on the following cycle; throughput one result per cycle, no stall or backpressure.
REQ-022 Combinational outputs SHALL be unaffected by rst; reset affects registered outputs only.
REQ-023 X or Z on any input SHALL NOT be masked; no internal defaulting of undriven inputs.

Reset
REQ-024 On a rising edge with rst=1: sum_q=0, cout_q=0, out_valid=0, regardless of in_valid.
REQ-025 rst SHALL take priority over in_valid on the same edge; input presented in that cycle is discarded.
REQ-026 Reset asserted mid-stream SHALL drop any result that would have appeared the next cycle; first valid result after release appears one cycle after the first in_valid=1 edge with rst=0.
REQ-027 Before the first reset edge, registered outputs are undefined; combinational outputs are valid immediately.

Verification
REQ-028 Exhaustive combinational sweep: (a,b,cin) = 000,001,010,011,100,101,110,111 -> (cout,sum) = 00,01,01,10,01,10,10,11, each checked without a clock edge.
REQ-029 Registered path: in_valid=1 with a=1,b=1,cin=1 at edge N -> sum_q=1, cout_q=1, out_valid=1 after edge N; in_valid=0 at edge N+1 -> out_valid=0, sum_q/cout_q still 1.
REQ-030 Streaming: 8 consecutive in_valid=1 cycles walking 000..111 -> out_valid=1 for 8 consecutive cycles, each registered result matching REQ-028 one cycle late.
REQ-031 Reset priority: rst=1 and in_valid=1 with a=1,b=1,cin=0 on the same edge -> sum_q=0, cout_q=0, out_valid=0; sum=0, cout=1 still combinationally.
REQ-032 Mid-stream reset: valid input 011 at edge N, rst=1 at edge N+1 -> after N+1 sum_q=0, cout_q=0, out_valid=0.
REQ-033 Propagate/generate: a=1,b=0 -> p=1,g=0; a=1,b=1 -> p=0,g=1; a=0,b=0 -> p=0,g=0.

Source files
------------

// File: rtl/full_adder_1b_if.sv
// Signal bundle for the 1-bit full adder: operand/carry inputs, combinational
// results and the registered result with its valid strobe.
interface full_adder_1b_if;
  logic a;
  logic b;
  logic cin;
  logic in_valid;
  logic sum;
  logic cout;
  logic p;
  logic g;
  logic sum_q;
  logic cout_q;
  logic out_valid;

  modport master (
    output a, b, cin, in_valid,
    input  sum, cout, p, g, sum_q, cout_q, out_valid
  );

  modport slave (
    input  a, b, cin, in_valid,
    output sum, cout, p, g, sum_q, cout_q, out_valid
  );
endinterface

// File: rtl/full_adder_1b.sv
// 1-bit full adder with zero-latency combinational outputs and a one-cycle
// registered copy of {cout,sum} qualified by in_valid.
module full_adder_1b (
  input  logic           clk,
  input  logic           rst,
  full_adder_1b_if.slave bus
);

  // Carry is formed from propagate/generate so p and g stay consistent with cout.
  assign bus.p    = bus.a ^ bus.b;
  assign bus.g    = bus.a & bus.b;
  assign bus.sum  = bus.p ^ bus.cin;
  assign bus.cout = bus.g | (bus.p & bus.cin);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sum_q     <= 1'b0;
      bus.cout_q    <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.sum_q  <= bus.sum;
        bus.cout_q <= bus.cout;
      end
    end
  end

endmodule

// File: tb/tb_full_adder_1b.sv
// Self-checking bench for full_adder_1b: directed scenarios plus randomized
// traffic compared against an arithmetic reference model.
module tb_full_adder_1b;

  logic clk = 1'b0;
  logic rst;
  full_adder_1b_if bus ();

  full_adder_1b dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic exp_sum_q, exp_cout_q, exp_valid;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ai, input logic bi, input logic ci, input logic vi);
    bus.a        = ai;
    bus.b        = bi;
    bus.cin      = ci;
    bus.in_valid = vi;
  endtask

  // Combinational outputs judged against plain integer addition.
  task automatic check_comb(input string tag);
    int total;
    #1;
    total = int'(bus.a) + int'(bus.b) + int'(bus.cin);
    chk({tag, "_sum_cout"}, {bus.cout, bus.sum}, 2'(total));
    chk({tag, "_p_g"}, {bus.p, bus.g}, {bus.a != bus.b, bus.a && bus.b});
  endtask

  // Advance one clock; the model sees the inputs as they stand at the edge.
  task automatic cycle(input string tag);
    int total;
    total = int'(bus.a) + int'(bus.b) + int'(bus.cin);
    if (rst) begin
      exp_sum_q  = 1'b0;
      exp_cout_q = 1'b0;
      exp_valid  = 1'b0;
    end else if (bus.in_valid) begin
      exp_sum_q  = (total % 2) == 1;
      exp_cout_q = (total / 2) == 1;
      exp_valid  = 1'b1;
    end else begin
      exp_valid  = 1'b0;
    end
    @(posedge clk);
    #1;
    chk({tag, "_reg"}, {bus.cout_q, bus.sum_q}, {exp_cout_q, exp_sum_q});
    chk({tag, "_valid"}, {1'b0, bus.out_valid}, {1'b0, exp_valid});
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    cycle("reset");

    // Exhaustive sweep with no clock edge involved, against literal truth table.
    begin
      logic [1:0] table_exp [8];
      table_exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
      @(posedge clk);
      #2;
      for (int i = 0; i < 8; i++) begin
        logic [2:0] v;
        v = 3'(i);
        drive(v[2], v[1], v[0], 1'b0);
        #1;
        chk("sweep", {bus.cout, bus.sum}, table_exp[i]);
        check_comb("sweep_model");
      end
    end

    drive(1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("pg_10", {bus.p, bus.g}, 2'b10);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    #1 chk("pg_11", {bus.p, bus.g}, 2'b01);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("pg_00", {bus.p, bus.g}, 2'b00);

    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    cycle("capture_111");
    chk("capture_111_lit", {bus.out_valid, bus.cout_q, bus.sum_q}, 2'b11);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    cycle("hold");
    chk("hold_lit", {bus.cout_q, bus.sum_q}, 2'b11);
    chk("hold_valid_lit", {1'b0, bus.out_valid}, 2'b00);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      drive(v[2], v[1], v[0], 1'b1);
      cycle("stream");
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    cycle("stream_end");

    // Reset wins over in_valid on the same edge; comb outputs ignore rst.
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    #1 chk("rst_prio_comb", {bus.cout, bus.sum}, 2'b10);
    cycle("rst_prio");
    chk("rst_prio_lit", {bus.out_valid, bus.cout_q, bus.sum_q}, 2'b00);

    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    cycle("mid_n");
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    cycle("mid_n1");
    rst = 1'b0;

    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 15) == 0);
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      check_comb("rand");
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
